// File: rtl/sram_bank_arbiter_pkg.sv
// Shared constants and types for the SRAM bank arbiter.
// Requester indices, default SRAM geometry and the read tag bundle.
package sram_bank_arbiter_pkg;

    localparam int NUM_REQ  = 4;
    localparam int REQ_NTSC = 3;
    localparam int REQ_VGA  = 2;
    localparam int REQ_LPF  = 1;
    localparam int REQ_PTF  = 0;

    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 36;

    typedef struct packed {
        logic               valid;
        logic [NUM_REQ-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Read tag delay line: carries {valid, id} of each granted read
// so the returning SRAM word can be routed to its requester.
module read_tag_pipe
    import sram_bank_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clock,
    input  logic    clear,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [DEPTH];

    // Shift one stage per cycle; clear drops every read in flight.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/sram_bank_arbiter.sv
// Single-bank SRAM arbiter: NTSC > starved LPF/PTF > VGA > LPF/PTF
// round-robin, with tagged fixed-latency read return.
module sram_bank_arbiter
    import sram_bank_arbiter_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    wr,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_write,
    output logic                  mem_wr,
    input  logic [DATA_W-1:0]     mem_read,
    output logic [15:0]           starve_events
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]         wait_cnt [2];
    logic [1:0]         starved;
    logic               rr_ptf;
    logic [15:0]        starve_cnt;
    logic [NUM_REQ-1:0] grant_c;
    logic [NUM_REQ-1:0] rr_pick;
    logic               starve_win;
    logic [DATA_W-1:0]  rdata_hold;
    rd_tag_t            tag_in;
    rd_tag_t            tag_tail;
    logic               unused_wr_ntsc;

    assign unused_wr_ntsc = wr[REQ_NTSC];

    // Starved means still requesting with the wait counter at the limit.
    always_comb begin
        starved = '0;
        for (int i = 0; i < 2; i++) begin
            starved[i] = req[i] && (wait_cnt[i] == LIMIT);
        end
    end

    assign rr_pick = rr_ptf ? 4'b0001 : 4'b0010;

    // Fixed-priority grant with the starvation override above VGA.
    always_comb begin
        grant_c    = '0;
        starve_win = 1'b0;
        if (!reset) begin
            if (req[REQ_NTSC]) begin
                grant_c[REQ_NTSC] = 1'b1;
            end else if (&starved) begin
                grant_c    = rr_pick;
                starve_win = 1'b1;
            end else if (starved[REQ_LPF]) begin
                grant_c[REQ_LPF] = 1'b1;
                starve_win       = 1'b1;
            end else if (starved[REQ_PTF]) begin
                grant_c[REQ_PTF] = 1'b1;
                starve_win       = 1'b1;
            end else if (req[REQ_VGA]) begin
                grant_c[REQ_VGA] = 1'b1;
            end else if (req[REQ_LPF] && req[REQ_PTF]) begin
                grant_c = rr_pick;
            end else if (req[REQ_LPF]) begin
                grant_c[REQ_LPF] = 1'b1;
            end else if (req[REQ_PTF]) begin
                grant_c[REQ_PTF] = 1'b1;
            end
        end
    end

    assign grant = grant_c;

    // Steer the granted requester onto the SRAM port.
    always_comb begin
        mem_addr  = '0;
        mem_write = '0;
        mem_wr    = 1'b0;
        unique case (1'b1)
            grant_c[REQ_NTSC]: begin
                mem_addr  = addr[REQ_NTSC*ADDR_W +: ADDR_W];
                mem_write = wdata[REQ_NTSC*DATA_W +: DATA_W];
                mem_wr    = 1'b1;
            end
            grant_c[REQ_VGA]: begin
                mem_addr  = addr[REQ_VGA*ADDR_W +: ADDR_W];
                mem_write = wdata[REQ_VGA*DATA_W +: DATA_W];
                mem_wr    = wr[REQ_VGA];
            end
            grant_c[REQ_LPF]: begin
                mem_addr  = addr[REQ_LPF*ADDR_W +: ADDR_W];
                mem_write = wdata[REQ_LPF*DATA_W +: DATA_W];
                mem_wr    = wr[REQ_LPF];
            end
            grant_c[REQ_PTF]: begin
                mem_addr  = addr[REQ_PTF*ADDR_W +: ADDR_W];
                mem_write = wdata[REQ_PTF*DATA_W +: DATA_W];
                mem_wr    = wr[REQ_PTF];
            end
            default: ;
        endcase
    end

    // Wait counters: count denied cycles, saturate at the limit.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || !req[i] || grant_c[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != LIMIT) begin
                wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end
        end
    end

    // Round-robin pointer flips to the other LPF/PTF after a grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptf <= 1'b0;
        end else if (grant_c[REQ_LPF]) begin
            rr_ptf <= 1'b1;
        end else if (grant_c[REQ_PTF]) begin
            rr_ptf <= 1'b0;
        end
    end

    // Saturating count of grants won through starvation.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (starve_win && starve_cnt != 16'hFFFF) begin
            starve_cnt <= starve_cnt + 16'd1;
        end
    end

    assign starve_events = starve_cnt;

    // NTSC is write-only, so only the lower three can issue reads.
    always_comb begin
        tag_in       = '0;
        tag_in.id    = grant_c & {1'b0, ~wr[2:0]};
        tag_in.valid = |tag_in.id;
    end

    read_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clock   (clock),
        .clear   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_tail)
    );

    // Capture each returned word so rdata holds between returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_hold <= '0;
        end else if (tag_tail.valid) begin
            rdata_hold <= mem_read;
        end
    end

    assign rvalid = (!reset && tag_tail.valid) ? tag_tail.id : '0;

    assign rdata = reset          ? '0 :
                   tag_tail.valid ? mem_read :
                                    rdata_hold;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Randomized scoreboard bench for sram_bank_arbiter.
// Reference model follows the priority and starvation rules directly.
module tb_sram_bank_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 36;
    localparam int LAT    = 2;
    localparam int LIMIT  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        req = '0;
    logic [3:0]        wr = '0;
    logic [4*ADDR_W-1:0] addr = '0;
    logic [4*DATA_W-1:0] wdata = '0;
    logic [3:0]        grant;
    logic [3:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_read = '0;
    logic [15:0]       starve_events;

    sram_bank_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .wr            (wr),
        .addr          (addr),
        .wdata         (wdata),
        .grant         (grant),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .mem_wr        (mem_wr),
        .mem_read      (mem_read),
        .starve_events (starve_events)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [3:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int   wcnt [2];
    int   rr_lpf = 1;
    int   sev = 0;
    logic [DATA_W-1:0] hold_model = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Reference model: one arbitration decision per cycle from the rules.
    task automatic check_cycle(output logic [3:0] eg);
        bit sl, sp, st;
        int gi;
        @(negedge clock);
        eg = '0;
        st = 0;
        gi = -1;
        sl = req[1] && wcnt[1] == LIMIT;
        sp = req[0] && wcnt[0] == LIMIT;
        if (!reset) begin
            if (req[3]) gi = 3;
            else if (sl || sp) begin
                st = 1;
                gi = (sl && sp) ? (rr_lpf ? 1 : 0) : (sl ? 1 : 0);
            end
            else if (req[2]) gi = 2;
            else if (req[1] && req[0]) gi = rr_lpf ? 1 : 0;
            else if (req[1]) gi = 1;
            else if (req[0]) gi = 0;
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("grant", 64'(grant), 64'(eg));
        chk("starve_events", 64'(starve_events), 64'(sev));
        if (gi < 0) begin
            chk("mem_addr", 64'(mem_addr), 64'd0);
            chk("mem_write", 64'(mem_write), 64'd0);
            chk("mem_wr", 64'(mem_wr), 64'd0);
        end else begin
            chk("mem_addr", 64'(mem_addr),
                64'(addr[gi*ADDR_W +: ADDR_W]));
            chk("mem_write", 64'(mem_write),
                64'(wdata[gi*DATA_W +: DATA_W]));
            chk("mem_wr", 64'(mem_wr), 64'(gi == 3 ? 1'b1 : wr[gi]));
        end
        if (reset) begin
            wcnt[0] = 0;
            wcnt[1] = 0;
            rr_lpf = 1;
            sev = 0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || eg[i]) wcnt[i] = 0;
                else if (wcnt[i] < LIMIT) wcnt[i]++;
            end
            if (eg[1]) rr_lpf = 0;
            if (eg[0]) rr_lpf = 1;
            if (st && sev < 65535) sev++;
            if (gi >= 0 && gi != 3 && !wr[gi])
                exp_q.push_back('{due: cyc + LAT, id: eg});
        end
    endtask

    // Monitor: every read return is matched against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            hold_model = '0;
            chk("rvalid_rst", 64'(rvalid), 64'd0);
            chk("rdata_rst", 64'(rdata), 64'd0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rvalid", 64'(rvalid), 64'(e.id));
            chk("rdata", 64'(rdata), 64'(mem_read));
            hold_model = mem_read;
        end else begin
            chk("rvalid_idle", 64'(rvalid), 64'd0);
            chk("rdata_hold", 64'(rdata), 64'(hold_model));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] w);
        req = r;
        wr = w;
        for (int i = 0; i < 4; i++) begin
            addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            wdata[i*DATA_W +: DATA_W] = DATA_W'({$urandom, $urandom});
        end
        mem_read = DATA_W'({$urandom, $urandom});
    endtask

    initial begin
        logic [3:0] eg;
        logic [3:0] rr_exp [6];
        bit pend [4];
        int rate [4];
        wcnt[0] = 0;
        wcnt[1] = 0;
        rr_exp = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        rate = '{50, 50, 40, 10};

        // Reset held with every requester asking.
        reset = 1'b1;
        set_in(4'hF, 4'h0);
        for (int c = 0; c < 3; c++) begin
            check_cycle(eg);
            chk("rst_grant", 64'(grant), 64'd0);
            chk("rst_mem_wr", 64'(mem_wr), 64'd0);
            tick();
        end
        reset = 1'b0;

        // NTSC wins over everyone.
        set_in(4'hF, 4'h0);
        addr[3*ADDR_W +: ADDR_W] = 19'h00010;
        check_cycle(eg);
        chk("prio_grant", 64'(grant), 64'h8);
        chk("prio_addr", 64'(mem_addr), 64'h10);
        chk("prio_wr", 64'(mem_wr), 64'd1);
        tick();
        set_in(4'h0, 4'h0);
        check_cycle(eg);
        tick();

        // LPF/PTF alternate, LPF first out of reset.
        for (int c = 0; c < 6; c++) begin
            set_in(4'b0011, 4'h0);
            check_cycle(eg);
            chk("rr_grant", 64'(grant), 64'(rr_exp[c]));
            tick();
        end
        set_in(4'h0, 4'h0);
        check_cycle(eg);
        tick();

        // LPF promoted above VGA after LIMIT denied cycles.
        for (int c = 0; c < 10; c++) begin
            set_in(4'b0110, 4'h0);
            check_cycle(eg);
            chk("starve_grant", 64'(grant),
                64'(c == LIMIT ? 4'b0010 : 4'b0100));
            if (c == LIMIT + 1)
                chk("starve_count", 64'(starve_events), 64'd1);
            tick();
        end
        for (int c = 0; c < LAT + 1; c++) begin
            set_in(4'h0, 4'h0);
            check_cycle(eg);
            tick();
        end

        // VGA read returns after LAT cycles, then rdata holds.
        set_in(4'b0100, 4'h0);
        addr[2*ADDR_W +: ADDR_W] = 19'h00100;
        check_cycle(eg);
        chk("rd_grant", 64'(grant), 64'h4);
        chk("rd_addr", 64'(mem_addr), 64'h100);
        tick();
        set_in(4'h0, 4'h0);
        check_cycle(eg);
        tick();
        set_in(4'h0, 4'h0);
        mem_read = 36'hABC;
        check_cycle(eg);
        chk("rd_rvalid", 64'(rvalid), 64'h4);
        chk("rd_rdata", 64'(rdata), 64'hABC);
        tick();
        set_in(4'h0, 4'h0);
        mem_read = 36'h123;
        check_cycle(eg);
        chk("rd_rvalid_off", 64'(rvalid), 64'h0);
        chk("rd_rdata_hold", 64'(rdata), 64'hABC);
        tick();

        // Reset drops an in-flight PTF read.
        set_in(4'b0001, 4'h0);
        check_cycle(eg);
        chk("ptf_grant", 64'(grant), 64'h1);
        tick();
        set_in(4'h0, 4'h0);
        reset = 1'b1;
        check_cycle(eg);
        tick();
        reset = 1'b0;
        set_in(4'h0, 4'h0);
        check_cycle(eg);
        chk("flush_rvalid", 64'(rvalid), 64'h0);
        chk("flush_rdata", 64'(rdata), 64'h0);

        // Random traffic; requesters hold req until granted.
        eg = '0;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if (eg[i]) pend[i] = 0;
                if (!pend[i] && $urandom_range(0, 99) < rate[i]) begin
                    pend[i] = 1;
                    wr[i] = 1'($urandom);
                    addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                    wdata[i*DATA_W +: DATA_W] =
                        DATA_W'({$urandom, $urandom});
                end
                req[i] = pend[i];
            end
            mem_read = DATA_W'({$urandom, $urandom});
            check_cycle(eg);
        end

        // Drain outstanding reads.
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            reset = 1'b0;
            set_in(4'h0, 4'h0);
            check_cycle(eg);
        end
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
